// File: rtl/sc_metadata_table.sv
// sc_metadata_table: per-lane note timestamp FIFOs presenting each lane's oldest entry to the note matcher
module sc_metadata_table #(
  parameter int LANES = 37,
  parameter int TW    = 16,
  parameter int DEPTH = 4,
  parameter int LW    = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                wr_en,
  input  logic [LW-1:0]       wr_lane,
  input  logic [TW-1:0]       wr_time,
  input  logic [LANES-1:0]    metadata_request,
  output logic [LANES-1:0]    metadata_available,
  output logic [LANES*TW-1:0] metadata_link,
  output logic                wr_ready,
  output logic                overflow,
  output logic                order_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [TW-1:0] mem_q [LANES][DEPTH];
  logic [TW-1:0] mem_d [LANES][DEPTH];
  logic [PW-1:0] rd_q [LANES];
  logic [PW-1:0] rd_d [LANES];
  logic [PW-1:0] wr_q [LANES];
  logic [PW-1:0] wr_d [LANES];
  logic [CW-1:0] cnt_q [LANES];
  logic [CW-1:0] cnt_d [LANES];
  logic [CW-1:0] post [LANES];
  logic [TW-1:0] last_q [LANES];
  logic [TW-1:0] last_d [LANES];
  logic [LANES-1:0] pop, hit, bad, acc;
  logic ovf_q, ovf_d, oerr_q, oerr_d;
  // full and ordering checks use the occupancy left after this cycle's pop
  always_comb begin
    mem_d    = mem_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    oerr_d   = oerr_q;
    wr_ready = 1'b0;
    pop      = '0;
    hit      = '0;
    bad      = '0;
    acc      = '0;
    post     = cnt_q;
    for (int i = 0; i < LANES; i++) begin
      pop[i]    = metadata_request[i] && cnt_q[i] != '0;
      post[i]   = cnt_q[i] - CW'(pop[i]);
      hit[i]    = wr_en && wr_lane == LW'(i);
      bad[i]    = post[i] != '0 && wr_time < last_q[i];
      acc[i]    = hit[i] && post[i] != FULL && !bad[i];
      wr_ready  = wr_ready | (wr_lane == LW'(i) && cnt_q[i] != FULL);
      ovf_d     = ovf_d | (hit[i] && post[i] == FULL);
      oerr_d    = oerr_d | (hit[i] && post[i] != FULL && bad[i]);
      rd_d[i]   = rd_q[i] + PW'(pop[i]);
      cnt_d[i]  = post[i] + CW'(acc[i]);
      wr_d[i]   = acc[i] ? wr_q[i] + 1'b1 : wr_q[i];
      last_d[i] = acc[i] ? wr_time : last_q[i];
      if (acc[i]) mem_d[i][wr_q[i]] = wr_time;
    end
  end
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < LANES; i++) begin
        rd_q[i]   <= '0;
        wr_q[i]   <= '0;
        cnt_q[i]  <= '0;
        last_q[i] <= '0;
      end
      ovf_q  <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      ovf_q  <= ovf_d;
      oerr_q <= oerr_d;
    end
  end
  // storage needs no reset: heads of empty lanes are masked to zero
  always_ff @(posedge clk) mem_q <= mem_d;
  always_comb begin
    metadata_available = '0;
    metadata_link      = '0;
    for (int i = 0; i < LANES; i++) begin
      metadata_available[i]   = cnt_q[i] != '0;
      metadata_link[TW*i +: TW] = cnt_q[i] != '0 ? mem_q[i][rd_q[i]] : '0;
    end
  end
  assign overflow  = ovf_q;
  assign order_err = oerr_q;
endmodule

// File: tb/tb_sc_metadata_table.sv
// tb_sc_metadata_table: queue-based reference model feeding a scoreboard checked by an independent monitor
module tb_sc_metadata_table;
  localparam int L = 37;
  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, wr_en = 1'b0;
  logic [5:0] wr_lane = '0;
  logic [15:0] wr_time = '0;
  logic [L-1:0] metadata_request = '0;
  logic [L-1:0] metadata_available;
  logic [L*16-1:0] metadata_link;
  logic wr_ready, overflow, order_err;
  typedef struct {
    logic [L-1:0]    av;
    logic [L*16-1:0] lk;
    logic            ov;
    logic            oe;
  } exp_t;
  exp_t exq[$];
  logic [15:0] mq [L][$];
  logic [15:0] m_last [L];
  logic m_ovf = 1'b0, m_oerr = 1'b0;
  int checks = 0, failures = 0;
  sc_metadata_table dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_lane(wr_lane),
    .wr_time(wr_time), .metadata_request(metadata_request),
    .metadata_available(metadata_available), .metadata_link(metadata_link),
    .wr_ready(wr_ready), .overflow(overflow), .order_err(order_err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [L-1:0] lb(input int i);
    return {{(L-1){1'b0}}, 1'b1} << i;
  endfunction
  function automatic logic [15:0] head(input int i);
    return metadata_link[16*i +: 16];
  endfunction
  // one clock of stimulus; the model's post-edge view goes to the scoreboard
  task automatic step(input bit we, input int wl, input logic [15:0] wt, input logic [L-1:0] rq,
                      input bit fl, input bit rs);
    exp_t e;
    @(negedge clk);
    reset = rs; flush = fl; wr_en = we; wr_lane = 6'(wl); wr_time = wt; metadata_request = rq;
    #1;
    if (wl < L) chk("wr_ready", 64'(wr_ready), 64'(mq[wl].size() < 4));
    if (rs || fl) begin
      for (int i = 0; i < L; i++) begin
        mq[i].delete();
        m_last[i] = '0;
      end
      m_ovf = 1'b0;
      m_oerr = 1'b0;
    end else begin
      for (int i = 0; i < L; i++)
        if (rq[i] && mq[i].size() > 0) void'(mq[i].pop_front());
      if (we && wl < L) begin
        if (mq[wl].size() == 4) m_ovf = 1'b1;
        else if (mq[wl].size() > 0 && wt < m_last[wl]) m_oerr = 1'b1;
        else begin
          mq[wl].push_back(wt);
          m_last[wl] = wt;
        end
      end
    end
    e.av = '0;
    e.lk = '0;
    for (int i = 0; i < L; i++) begin
      e.av[i] = mq[i].size() > 0;
      if (mq[i].size() > 0) e.lk[16*i +: 16] = mq[i][0];
    end
    e.ov = m_ovf;
    e.oe = m_oerr;
    exq.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0; flush = 1'b0; wr_en = 1'b0; metadata_request = '0;
  endtask
  task automatic wr(input int wl, input logic [15:0] wt);
    step(1'b1, wl, wt, '0, 1'b0, 1'b0);
  endtask
  task automatic rq(input logic [L-1:0] r);
    step(1'b0, 0, 16'h0, r, 1'b0, 1'b0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exq.size() > 0) begin
        e = exq.pop_front();
        checks += 4;
        if (metadata_available !== e.av) begin
          failures++;
          $display("FAIL avail: got %h expected %h", metadata_available, e.av);
        end
        if (metadata_link !== e.lk) begin
          failures++;
          $display("FAIL link: got %h expected %h", metadata_link, e.lk);
        end
        if (overflow !== e.ov) begin
          failures++;
          $display("FAIL overflow: got %b expected %b", overflow, e.ov);
        end
        if (order_err !== e.oe) begin
          failures++;
          $display("FAIL order_err: got %b expected %b", order_err, e.oe);
        end
      end
    end
  end
  initial begin
    logic [L-1:0] r;
    logic [15:0] t;
    int wl;
    for (int i = 0; i < L; i++) m_last[i] = '0;
    step(1'b0, 0, 16'h0, '0, 1'b0, 1'b1);
    chk("reset_avail", 64'(metadata_available), 64'h0);
    wr(3, 16'h0100);
    chk("t1_avail3", 64'(metadata_available), 64'(lb(3)));
    chk("t1_head3", 64'(head(3)), 64'h0100);
    foreach (m_last[k]) ;
    for (int i = 0; i < 4; i++) wr(5, 16'(10 * (i + 1)));
    chk("t2_ready_full", 64'(wr_ready), 64'h0);
    wr(5, 16'd50);
    chk("t2_overflow", 64'(overflow), 64'h1);
    chk("t2_head5", 64'(head(5)), 64'd10);
    for (int i = 0; i < 4; i++) begin
      chk("t2_pop_seq", 64'(head(5)), 64'(10 * (i + 1)));
      rq(lb(5));
    end
    chk("t2_empty5", 64'(metadata_available[5]), 64'h0);
    chk("t2_link5", 64'(head(5)), 64'h0);
    step(1'b0, 0, 16'h0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) wr(5, 16'(10 * (i + 1)));
    step(1'b1, 5, 16'd50, lb(5), 1'b0, 1'b0);
    chk("t3_overflow", 64'(overflow), 64'h0);
    chk("t3_head", 64'(head(5)), 64'd20);
    chk("t3_still_full", 64'(wr_ready), 64'h0);
    for (int i = 0; i < 3; i++) rq(lb(5));
    chk("t3_tail", 64'(head(5)), 64'd50);
    wr(2, 16'd200);
    wr(2, 16'd150);
    chk("t4_order_err", 64'(order_err), 64'h1);
    chk("t4_head2", 64'(head(2)), 64'd200);
    step(1'b0, 0, 16'h0, '0, 1'b1, 1'b0);
    chk("t4_flush_avail", 64'(metadata_available), 64'h0);
    chk("t4_flush_oerr", 64'(order_err), 64'h0);
    wr(0, 16'd7);
    wr(0, 16'd8);
    wr(36, 16'd9);
    rq('1);
    chk("t5_head0", 64'(head(0)), 64'd8);
    chk("t5_avail", 64'(metadata_available), 64'(lb(0)));
    wr(37, 16'd1);
    chk("t5_bad_lane", 64'({overflow, order_err}), 64'h0);
    rq(lb(0));
    wr(0, 16'd1);
    for (int i = 0; i < 12; i++) step(1'b1, 0, 16'(i + 2), lb(0), 1'b0, 1'b0);
    chk("t6_head0", 64'(head(0)), 64'd13);
    for (int i = 0; i < 5; i++) wr(9, 16'd3);
    step(1'b1, 0, 16'h99, lb(0), 1'b0, 1'b1);
    chk("t6_reset", 64'({|metadata_link, |metadata_available, overflow, order_err}), 64'h0);
    for (int n = 0; n < 500; n++) begin
      wl = $urandom_range(0, 38);
      r = '0;
      for (int b = 0; b < L; b++) r[b] = ($urandom_range(0, 2) == 0);
      t = 16'h0;
      if (wl < L) begin
        t = m_last[wl] + 16'($urandom_range(0, 20));
        if ($urandom_range(0, 7) == 0 && m_last[wl] >= 16'd5) t = m_last[wl] - 16'($urandom_range(1, 5));
        if (r[wl] && mq[wl].size() == 1 && t < m_last[wl]) t = m_last[wl];
      end
      step($urandom_range(0, 3) != 0, wl, t, r, $urandom_range(0, 59) == 0, $urandom_range(0, 99) == 0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drain", 64'(exq.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
